// File: rtl/level_led_sequencer.sv
// rtl/level_led_sequencer.sv - level LED display with flash, chase and blink effects
// One registered FSM drives the LEDs from the captured level or the current effect.
module level_led_sequencer #(
  parameter int NUM_LEDS    = 4,
  parameter int LEVEL_W     = 4,
  parameter int MAX_LEVEL   = 8,
  parameter int BLINK_DIV   = 4,
  parameter int FLASH_COUNT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [LEVEL_W-1:0]  curr_level,
  input  logic                level_load,
  input  logic                win,
  input  logic                lose,
  input  logic                clear,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy
);

  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int FW = $clog2(FLASH_COUNT + 1);
  localparam logic [PW-1:0] STEP_LAST  = PW'(BLINK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_COUNT);

  typedef enum logic [1:0] {SHOW, FLASH, WIN, LOSE} state_t;

  function automatic logic [NUM_LEDS-1:0] err_pattern();
    logic [NUM_LEDS-1:0] p;
    for (int i = 0; i < NUM_LEDS; i++) p[i] = ((i % 2) == ((NUM_LEDS - 1) % 2));
    return p;
  endfunction

  function automatic logic [NUM_LEDS-1:0] disp(input logic [LEVEL_W-1:0] l);
    int lv;
    lv = int'(l);
    if (lv >= 1 && lv <= MAX_LEVEL) return NUM_LEDS'(l);
    return err_pattern();
  endfunction

  state_t              state_q, state_d;
  logic [LEVEL_W-1:0]  lvl_q, lvl_d;
  logic [PW-1:0]       phase_cnt_q, phase_cnt_d;
  logic [FW-1:0]       flash_cnt_q, flash_cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                busy_q, busy_d;
  logic                step;
  logic                run;

  always_comb begin
    state_d     = state_q;
    lvl_d       = level_load ? curr_level : lvl_q;
    phase_cnt_d = phase_cnt_q;
    flash_cnt_d = flash_cnt_q;
    phase_d     = phase_q;
    led_d       = led_q;
    step        = tick && (phase_cnt_q == STEP_LAST);
    run         = 1'b0;

    // Strobe priority; a strobe that would re-enter the current effect just lets it run on.
    if (lose) begin
      if (state_q != LOSE) begin
        state_d     = LOSE;
        led_d       = '1;
        phase_cnt_d = '0;
      end else begin
        run = 1'b1;
      end
    end else if (win && state_q != LOSE) begin
      if (state_q != WIN) begin
        state_d     = WIN;
        led_d       = NUM_LEDS'(1);
        phase_cnt_d = '0;
      end else begin
        run = 1'b1;
      end
    end else if (clear) begin
      state_d     = SHOW;
      led_d       = disp(lvl_d);
      phase_cnt_d = '0;
    end else if (level_load && (state_q == SHOW || state_q == FLASH)) begin
      state_d     = FLASH;
      led_d       = disp(lvl_d);
      phase_cnt_d = '0;
      flash_cnt_d = '0;
      phase_d     = 1'b1;
    end else begin
      run = 1'b1;
    end

    if (run) begin
      if (tick) phase_cnt_d = step ? '0 : phase_cnt_q + 1'b1;
      case (state_q)
        SHOW: led_d = disp(lvl_d);
        FLASH: begin
          if (step) begin
            phase_d = ~phase_q;
            if (!phase_q) flash_cnt_d = flash_cnt_q + 1'b1;
          end
          if (phase_d && flash_cnt_d == FLASH_LAST) begin
            state_d = SHOW;
            led_d   = disp(lvl_d);
          end else begin
            led_d = phase_d ? disp(lvl_d) : '0;
          end
        end
        WIN:  if (step) led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
        LOSE: if (step) led_d = ~led_q;
      endcase
    end

    busy_d = (state_d != SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW;
      lvl_q       <= '0;
      phase_cnt_q <= '0;
      flash_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      phase_cnt_q <= phase_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_level_led_sequencer.sv
// tb/tb_level_led_sequencer.sv - self-checking bench for level_led_sequencer
// Reference model tracks mode, level and ticks since entry; LEDs derive from step counts.
module tb_level_led_sequencer;
  localparam int N = 4, LW = 4, ML = 8, BD = 4, FC = 3;

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic level_load = 1'b0, win = 1'b0, lose = 1'b0, clear = 1'b0;
  logic [LW-1:0] curr_level = '0;
  logic [N-1:0]  led;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef enum {M_SHOW, M_FLASH, M_WIN, M_LOSE} mode_t;
  mode_t m_mode = M_SHOW;
  int    m_lvl  = 0;
  int    m_t    = 0;

  level_led_sequencer #(.NUM_LEDS(N), .LEVEL_W(LW), .MAX_LEVEL(ML),
                        .BLINK_DIV(BD), .FLASH_COUNT(FC)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .curr_level(curr_level),
    .level_load(level_load), .win(win), .lose(lose), .clear(clear),
    .led(led), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [3:0] disp_m(input int l);
    if (l >= 1 && l <= ML) return 4'(l);
    return 4'b1010;
  endfunction

  function automatic logic [3:0] exp_led();
    int s;
    s = m_t / BD;
    case (m_mode)
      M_SHOW:  return disp_m(m_lvl);
      M_FLASH: return (s % 2 == 0) ? disp_m(m_lvl) : 4'b0000;
      M_WIN:   return 4'(1 << (s % N));
      default: return (s % 2 == 0) ? 4'b1111 : 4'b0000;
    endcase
  endfunction

  function automatic logic exp_busy();
    return m_mode != M_SHOW;
  endfunction

  task automatic model_reset();
    m_mode = M_SHOW;
    m_lvl  = 0;
    m_t    = 0;
  endtask

  // One clock: drive inputs at negedge, advance the model at posedge, leave at posedge+1.
  task automatic cyc(input logic tk, input logic ld, input int lv,
                     input logic w, input logic ls, input logic cl);
    logic entered;
    @(negedge clk);
    tick = tk; level_load = ld; curr_level = LW'(lv); win = w; lose = ls; clear = cl;
    @(posedge clk);
    entered = 1'b0;
    if (ls) begin
      if (m_mode != M_LOSE) begin m_mode = M_LOSE; m_t = 0; entered = 1'b1; end
    end else if (w && m_mode != M_LOSE) begin
      if (m_mode != M_WIN) begin m_mode = M_WIN; m_t = 0; entered = 1'b1; end
    end else if (cl) begin
      m_mode = M_SHOW; m_t = 0; entered = 1'b1;
    end else if (ld && (m_mode == M_SHOW || m_mode == M_FLASH)) begin
      m_mode = M_FLASH; m_t = 0; entered = 1'b1;
    end
    if (ld) m_lvl = lv % 16;
    if (!entered && tk) m_t++;
    if (m_mode == M_FLASH && m_t / BD >= 2 * FC) begin m_mode = M_SHOW; m_t = 0; end
    #1;
    tick = 1'b0; level_load = 1'b0; win = 1'b0; lose = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (led !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold led=%b busy=%b want led=0000 busy=0", led, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(i[0], 0, 0, 0, 0, 0);
      total++;
      if (led !== 4'b1010 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_err cyc=%0d led=%b busy=%b want led=1010 busy=0", i, led, busy);
      end
    end
  endtask

  task automatic test_flash();
    int ticks = 0, darks = 0;
    logic [3:0] prev;
    cyc(0, 1, 5, 0, 0, 0);
    total++;
    if (led !== 4'b0101 || busy !== 1'b1) begin
      bad++;
      $display("FAIL flash_entry led=%b busy=%b want led=0101 busy=1", led, busy);
    end
    prev = led;
    for (int i = 0; i < 100 && busy === 1'b1; i++) begin
      cyc(i[0], 0, 0, 0, 0, 0);
      if (i[0]) ticks++;
      if (led === 4'b0000 && prev !== 4'b0000) darks++;
      prev = led;
      total++;
      if (led !== exp_led() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL flash_seq cyc=%0d led=%b busy=%b want led=%b busy=%b",
                 i, led, busy, exp_led(), exp_busy());
      end
    end
    total++;
    if (ticks != 24 || darks != 3 || led !== 4'b0101 || busy !== 1'b0) begin
      bad++;
      $display("FAIL flash_end ticks=%0d darks=%0d led=%b busy=%b want 24 3 0101 0",
               ticks, darks, led, busy);
    end
  endtask

  task automatic test_err_levels();
    int lvls[2] = '{9, 0};
    foreach (lvls[k]) begin
      cyc(1, 1, lvls[k], 0, 0, 0);
      total++;
      if (led !== 4'b1010 || busy !== 1'b1) begin
        bad++;
        $display("FAIL err_entry lvl=%0d led=%b busy=%b want 1010 1", lvls[k], led, busy);
      end
      for (int i = 0; i < 26; i++) begin
        cyc(1, 0, 0, 0, 0, 0);
        total++;
        if (led !== exp_led() || busy !== exp_busy()) begin
          bad++;
          $display("FAIL err_seq lvl=%0d cyc=%0d led=%b busy=%b want %b %b",
                   lvls[k], i, led, busy, exp_led(), exp_busy());
        end
      end
      total++;
      if (led !== 4'b1010 || busy !== 1'b0) begin
        bad++;
        $display("FAIL err_steady lvl=%0d led=%b busy=%b want 1010 0", lvls[k], led, busy);
      end
    end
  endtask

  task automatic test_win_lose();
    logic [3:0] held;
    cyc(1, 0, 0, 1, 0, 0);
    total++;
    if (led !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL win_entry led=%b busy=%b want 0001 1", led, busy);
    end
    for (int i = 0; i < 18; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (led !== exp_led() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL win_chase cyc=%0d led=%b want %b", i, led, exp_led());
      end
    end
    cyc(1, 0, 0, 0, 1, 0);
    total++;
    if (led !== 4'b1111 || busy !== 1'b1) begin
      bad++;
      $display("FAIL lose_entry led=%b busy=%b want 1111 1", led, busy);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (led !== exp_led() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL lose_blink cyc=%0d led=%b want %b", i, led, exp_led());
      end
    end
    held = led;
    cyc(0, 0, 0, 1, 0, 0);
    total++;
    if (led !== held || busy !== 1'b1) begin
      bad++;
      $display("FAIL win_in_lose led=%b busy=%b want %b 1", led, busy, held);
    end
    cyc(0, 1, 6, 0, 0, 0);
    total++;
    if (led !== held || busy !== 1'b1) begin
      bad++;
      $display("FAIL load_in_lose led=%b busy=%b want %b 1", led, busy, held);
    end
    cyc(0, 0, 0, 0, 0, 1);
    total++;
    if (led !== 4'b0110 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_show led=%b busy=%b want 0110 0", led, busy);
    end
  endtask

  task automatic test_priority();
    cyc(1, 1, 3, 1, 1, 0);
    total++;
    if (led !== 4'b1111 || busy !== 1'b1) begin
      bad++;
      $display("FAIL prio_lose led=%b busy=%b want 1111 1", led, busy);
    end
    cyc(0, 0, 0, 0, 0, 1);
    total++;
    if (led !== 4'b0011 || busy !== 1'b0) begin
      bad++;
      $display("FAIL prio_clear led=%b busy=%b want 0011 0", led, busy);
    end
  endtask

  task automatic test_async_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) cyc(0, 1, 2, 0, 0, 0);
      else           cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (led !== 4'b0000 || busy !== 1'b0) begin
        bad++;
        $display("FAIL async_rst pass=%0d led=%b busy=%b want 0000 0", pass, led, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 12; i++) begin
        cyc(1, 0, 0, 0, 0, 0);
        total++;
        if (led !== 4'b1010 || busy !== 1'b0) begin
          bad++;
          $display("FAIL post_rst pass=%0d cyc=%0d led=%b busy=%b want 1010 0",
                   pass, i, led, busy);
        end
      end
    end
  endtask

  task automatic test_random();
    logic tk, ld, w, ls, cl;
    int lv;
    for (int i = 0; i < 600; i++) begin
      tk = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 19) == 0);
      w  = ($urandom_range(0, 39) == 0);
      ls = ($urandom_range(0, 59) == 0);
      cl = ($urandom_range(0, 29) == 0);
      lv = int'($urandom_range(0, 15));
      cyc(tk, ld, lv, w, ls, cl);
      total++;
      if (led !== exp_led() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL random cyc=%0d led=%b busy=%b want %b %b",
                 i, led, busy, exp_led(), exp_busy());
      end
    end
  endtask

  initial begin
    test_reset();
    test_flash();
    test_err_levels();
    test_win_lose();
    test_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
